// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack driven by the CPU controller, one push/pop/tos command per cycle.
// Latency: pop/tos data on d_out one cycle after the command; no backpressure, every cycle accepts a command.
// Optional STACK_GUARD_EN: push-on-full and read-on-empty are dropped and raise sticky ovf/unf flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [WIDTH-1:0]           d_in,
    output logic [WIDTH-1:0]           d_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);
    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = SPW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] top;
    logic             wr_en;

    assign count = cnt_q;
    assign d_out = dout_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign top   = mem[sp_q - SPW'(1)];

`ifdef STACK_GUARD_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    // push outranks pop, pop outranks tos; losers in the same cycle are dropped
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        wr_en  = 1'b0;
`ifdef STACK_GUARD_EN
        ovf_d  = ovf_q;
        unf_d  = unf_q;
`endif
        if (push) begin
`ifdef STACK_GUARD_EN
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                sp_d  = sp_q + SPW'(1);
                cnt_d = cnt_q + CW'(1);
            end
`else
            // on full the pointer wraps and overwrites the oldest entry
            wr_en = 1'b1;
            sp_d  = sp_q + SPW'(1);
            if (!full) cnt_d = cnt_q + CW'(1);
`endif
        end else if (pop || tos) begin
`ifdef STACK_GUARD_EN
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                dout_d = top;
                if (pop) begin
                    sp_d  = sp_q - SPW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
`else
            dout_d = top;
            if (pop) begin
                sp_d = sp_q - SPW'(1);
                if (!empty) cnt_d = cnt_q - CW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
`endif

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en) mem[sp_q] <= d_in;
    end
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: reference stack model feeds a queue of expected d_out values,
// compared one cycle after each pop/tos; count/flags checked every command.
module tb_stack_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0, pop = 1'b0, tos = 1'b0;
    logic [7:0] d_in = '0;
    logic [7:0] d_out;
    logic [3:0] count;
    logic       empty, full, ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [8];
    int         m_sp = 0, m_cnt = 0;
    logic [7:0] m_dout = '0;
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0] exp_q [$];

    stack_unit #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
        .d_out(d_out), .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_cnt));
        check({tag, "_empty"}, 32'(empty), 32'(m_cnt == 0));
        check({tag, "_full"},  32'(full),  32'(m_cnt == 8));
        check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, "_unf"},   32'(unf),   32'(m_unf));
    endtask

    task automatic model_reset();
        m_sp = 0; m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        exp_q.delete();
    endtask

    // drive one command for one clock, update the model, then compare
    task automatic cmd(input string tag, input logic p, input logic po, input logic t,
                       input logic [7:0] d);
        logic       rd;
        logic [7:0] exp;
        rd = !p && (po || t);
        push = p; pop = po; tos = t; d_in = d;
        if (p) begin
            if (m_cnt == 8) begin
`ifdef STACK_GUARD_EN
                m_ovf = 1'b1;
`else
                m_mem[m_sp] = d;
                m_sp = (m_sp + 1) % 8;
`endif
            end else begin
                m_mem[m_sp] = d;
                m_sp = (m_sp + 1) % 8;
                m_cnt++;
            end
        end else if (rd) begin
            if (m_cnt == 0) begin
`ifdef STACK_GUARD_EN
                m_unf = 1'b1;
`else
                m_dout = m_mem[(m_sp + 7) % 8];
                if (po) m_sp = (m_sp + 7) % 8;
`endif
            end else begin
                m_dout = m_mem[(m_sp + 7) % 8];
                if (po) begin
                    m_sp = (m_sp + 7) % 8;
                    m_cnt--;
                end
            end
            exp_q.push_back(m_dout);
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; d_in = '0;
        if (rd) begin
            exp = exp_q.pop_front();
            check({tag, "_dout"}, 32'(d_out), 32'(exp));
        end
        check_state(tag);
    endtask

    initial begin
        logic [2:0] r;
        logic [7:0] held;
        #2;
        check("rst_dout", 32'(d_out), 32'h0);
        check_state("rst");
        @(negedge clk); rst = 1'b1;

        // 1: asynchronous reset in the middle of a burst
        cmd("t1_push", 1, 0, 0, 8'h01);
        cmd("t1_push", 1, 0, 0, 8'h02);
        cmd("t1_push", 1, 0, 0, 8'h03);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("t1_rst_count", 32'(count), 32'h0);
        check("t1_rst_empty", 32'(empty), 32'h1);
        check("t1_rst_dout",  32'(d_out), 32'h0);
        @(negedge clk); rst = 1'b1;
        cmd("t1_push11", 1, 0, 0, 8'h11);
        check("t1_count1", 32'(count), 32'h1);
        cmd("t1_pop", 0, 1, 0, 8'h00);

        // 2: back-to-back pushes then tos/pop
        cmd("t2_push", 1, 0, 0, 8'h05);
        cmd("t2_push", 1, 0, 0, 8'h0A);
        cmd("t2_push", 1, 0, 0, 8'h0F);
        cmd("t2_tos", 0, 0, 1, 8'h00);
        check("t2_tos_val", 32'(d_out), 32'h0F);
        check("t2_tos_cnt", 32'(count), 32'h3);
        cmd("t2_pop1", 0, 1, 0, 8'h00);
        check("t2_pop1_val", 32'(d_out), 32'h0F);
        cmd("t2_pop2", 0, 1, 0, 8'h00);
        check("t2_pop2_val", 32'(d_out), 32'h0A);
        check("t2_pop2_cnt", 32'(count), 32'h1);
        cmd("t2_pop3", 0, 1, 0, 8'h00);

        // 3: fill to full, drain to empty
        for (int i = 1; i <= 8; i++) cmd("t3_fill", 1, 0, 0, 8'(i));
        check("t3_full", 32'(full), 32'h1);
        for (int i = 8; i >= 1; i--) begin
            cmd("t3_drain", 0, 1, 0, 8'h00);
            check("t3_drain_val", 32'(d_out), 32'(i));
        end
        check("t3_empty", 32'(empty), 32'h1);

        // 4/5: push on full and pop on empty
        for (int i = 1; i <= 8; i++) cmd("t45_fill", 1, 0, 0, 8'(i));
        cmd("t45_push_full", 1, 0, 0, 8'hAA);
        check("t45_cnt", 32'(count), 32'h8);
        cmd("t45_tos", 0, 0, 1, 8'h00);
`ifdef STACK_GUARD_EN
        check("t4_ovf", 32'(ovf), 32'h1);
        check("t4_top", 32'(d_out), 32'h08);
`else
        check("t5_ovf", 32'(ovf), 32'h0);
        check("t5_top", 32'(d_out), 32'hAA);
`endif
        for (int i = 0; i < 8; i++) cmd("t45_drain", 0, 1, 0, 8'h00);
        held = d_out;
        cmd("t45_pop_empty", 0, 1, 0, 8'h00);
        check("t45_cnt0", 32'(count), 32'h0);
`ifdef STACK_GUARD_EN
        check("t4_unf", 32'(unf), 32'h1);
        check("t4_dout_hold", 32'(d_out), 32'(held));
`else
        check("t5_unf", 32'(unf), 32'h0);
`endif
        rst = 1'b0; #1; model_reset();
        @(negedge clk); rst = 1'b1;

        // 6: push and pop together, push wins
        cmd("t6_push22", 1, 0, 0, 8'h22);
        cmd("t6_tos22", 0, 0, 1, 8'h00);
        held = d_out;
        cmd("t6_both", 1, 1, 0, 8'h33);
        check("t6_cnt", 32'(count), 32'h2);
        check("t6_dout_hold", 32'(d_out), 32'(held));
        cmd("t6_tos", 0, 0, 1, 8'h00);
        check("t6_tos_val", 32'(d_out), 32'h33);

        // random command mix against the model
        for (int i = 0; i < 200; i++) begin
            r = 3'($urandom_range(0, 7));
            cmd("rnd", r[0], r[1], r[2], 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
# stack_unit

- LIFO operand stack for the multi-cycle stack-machine CPU.
- Executes the `push`/`pop`/`tos` commands that the CPU controller FSM issues, one command per cycle.
- Presents the selected stack entry on a registered output so the datapath can load it into A or B, or forward it to memory, on the following cycle.
- Sits beside the ALU operand registers; its only command source is the controller.

## Interface

Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 8: number of stack entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `push`, input, 1: write `d_in` to the top of the stack.
- `pop`, input, 1: remove the top entry and copy it to `d_out`.
- `tos`, input, 1: copy the top entry to `d_out` without removing it.
- `d_in`, input, WIDTH: push data (memory read data or ALU result, muxed upstream).
- `d_out`, output, WIDTH: registered read data.
- `count`, output, $clog2(DEPTH)+1: number of valid entries.
- `empty`, output, 1: high when `count == 0`. Combinational from `count`.
- `full`, output, 1: high when `count == DEPTH`. Combinational from `count`.
- `ovf`, output, 1: sticky overflow flag.
- `unf`, output, 1: sticky underflow flag.

## Operation

- Storage is a register array `mem[0..DEPTH-1]`.
- `sp` is a $clog2(DEPTH)-bit write pointer: the index of the next free slot. The top entry is `mem[sp-1]`, computed modulo DEPTH.
- Reset values: `sp=0`, `count=0`, `d_out=0`, `ovf=0`, `unf=0`, so `empty=1` and `full=0`. `mem` is not reset; its contents are undefined.
- Command priority when several are asserted in the same cycle: `push` > `pop` > `tos`. Lower-priority commands in that cycle are ignored entirely.
- **push:** `mem[sp] <= d_in`, `sp <= sp+1`, `count <= count+1`. `d_out` is unchanged.
- **pop:** `d_out <= mem[sp-1]`, `sp <= sp-1`, `count <= count-1`.
- **tos:** `d_out <= mem[sp-1]`. `sp` and `count` are unchanged.
- **No command:** all state holds.
- Boundary conditions (mode-dependent): see Configuration.
- `count` saturates in both modes: it never exceeds DEPTH and never goes below 0.
- **Reset mid-operation:** asserting `rst` low immediately forces all reset values, regardless of `clk` or any command in flight. Release is synchronous to `clk` upstream; the first command is honoured on the first rising edge with `rst=1`.

## Timing

- All outputs change only on the rising edge of `clk` or on assertion of `rst`.
- Read latency is 1 cycle. For `pop` or `tos` sampled at edge N, `d_out` is valid after edge N and holds until the next successful `pop` or `tos`. This matches the controller's pattern of `pop` in one state followed by `ld_A` or `ld_B` in the next.
- Push-to-read: a `push` at edge N is visible to a `tos` or `pop` sampled at edge N+1. No bypass is needed, because the controller never issues a read in the same cycle as a push.
- There is no ready/valid handshake. The block accepts one command every cycle, back-to-back, with no stall.
- The `ovf` and `unf` flags update at the same edge as the offending command.

## Configuration

- Macro: `STACK_GUARD_EN`.
- **Defined:**
  - `push` while `full` is ignored: no write, no change to `sp` or `count`. Sets `ovf`.
  - `pop` or `tos` while `empty` is ignored: `d_out` holds, no change to `sp` or `count`. Sets `unf`.
  - `ovf` and `unf` clear only on reset.
- **Not defined:**
  - `ovf` and `unf` are tied to 0.
  - `push` while `full` writes `mem[sp]` and `sp` wraps, overwriting the oldest entry. `count` stays at DEPTH.
  - `pop` while `empty` reads `mem[sp-1]` and `sp` wraps. `count` stays at 0.
  - `tos` while `empty` reads `mem[sp-1]`.

## Test plan

1. Reset `rst=0` mid-stream after 3 pushes -> immediately `count=0`, `empty=1`, `d_out=0`. Then push 0x11 -> `count=1`.
2. Push 0x05, 0x0A, 0x0F back-to-back; `tos` -> `d_out=0x0F` after 1 cycle, `count=3`. Then pop, pop -> `d_out=0x0F` then `0x0A`, `count=1`.
3. Push 8 values 0x01..0x08 -> `full=1`. Pop 8 times -> `d_out` sequence 0x08..0x01, `empty=1` after the last pop.
4. With `STACK_GUARD_EN`, DEPTH=8 full: push 0xAA -> `ovf=1`, `count=8`, top still 0x08. Empty stack, pop -> `unf=1`, `d_out` unchanged, `count=0`.
5. Without `STACK_GUARD_EN`: full stack holding 0x01..0x08, push 0xAA -> `mem[0]=0xAA`, `tos` returns 0xAA, `count=8`, `ovf=0`.
6. `push=1`, `pop=1`, `d_in=0x33` in the same cycle on a stack with top 0x22 -> push wins: `count` increments by 1, `d_out` unchanged, next `tos` gives 0x33.
